// File: rtl/regs_wb_arbiter.sv
// Writeback arbiter: shares the register file write port between the ALU and mul/div unit.
// Optional busy-register scoreboard enabled by defining REGS_WB_SCOREBOARD_EN.
module regs_wb_arbiter #(
   parameter int DATA_W       = 32,
   parameter int ADDR_W       = 5,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  alu_valid,
   input  logic [ADDR_W-1:0]     alu_addr,
   input  logic [DATA_W-1:0]     alu_data,
   output logic                  alu_ready,
   input  logic                  md_valid,
   input  logic [ADDR_W-1:0]     md_addr,
   input  logic [DATA_W-1:0]     md_data,
   output logic                  md_ready,
   input  logic                  md_issue_valid,
   input  logic [ADDR_W-1:0]     md_issue_addr,
   output logic [ADDR_W-1:0]     c_addr,
   output logic                  c_we,
   output logic [DATA_W-1:0]     c_in,
   output logic [2**ADDR_W-1:0]  busy_mask
);

   localparam int         NREG  = 2**ADDR_W;
   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic [3:0]        r_waitCnt;
   logic              r_cWe;
   logic [ADDR_W-1:0] r_cAddr;
   logic [DATA_W-1:0] r_cIn;

   logic              w_mdGrant;
   logic              w_aluGrant;
   logic              w_mdXfer;
   logic              w_aluXfer;
   logic [ADDR_W-1:0] w_wbAddr;
   logic [DATA_W-1:0] w_wbData;

   // Mul/div only wins over a pending ALU result once it has been starved long enough.
   always_comb begin
      w_mdGrant  = md_valid & (~alu_valid | (r_waitCnt >= LIMIT));
      w_aluGrant = alu_valid & ~w_mdGrant;
      w_mdXfer   = w_mdGrant & ~rst;
      w_aluXfer  = w_aluGrant & ~rst;
      w_wbAddr   = w_mdXfer ? md_addr : alu_addr;
      w_wbData   = w_mdXfer ? md_data : alu_data;
   end

   assign md_ready  = w_mdXfer;
   assign alu_ready = w_aluXfer;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_waitCnt <= '0;
      end else if (md_valid && !w_mdGrant) begin
         if (r_waitCnt != 4'hF) begin
            r_waitCnt <= r_waitCnt + 4'd1;
         end
      end else begin
         r_waitCnt <= '0;
      end
   end

   // Writes to register 0 are accepted but never reach the register file.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cWe   <= 1'b0;
         r_cAddr <= '0;
         r_cIn   <= '0;
      end else begin
         r_cWe <= (w_mdXfer || w_aluXfer) && (w_wbAddr != '0);
         if ((w_mdXfer || w_aluXfer) && (w_wbAddr != '0)) begin
            r_cAddr <= w_wbAddr;
            r_cIn   <= w_wbData;
         end
      end
   end

   assign c_we   = r_cWe;
   assign c_addr = r_cAddr;
   assign c_in   = r_cIn;

`ifdef REGS_WB_SCOREBOARD_EN
   logic [NREG-1:0] r_busy;
   logic [NREG-1:0] w_busyNext;

   // Issue is applied after writeback so a same-cycle set beats the clear.
   always_comb begin
      w_busyNext = r_busy;
      if (w_mdXfer) begin
         w_busyNext[md_addr] = 1'b0;
      end
      if (md_issue_valid && (md_issue_addr != '0)) begin
         w_busyNext[md_issue_addr] = 1'b1;
      end
      w_busyNext[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_busy <= '0;
      end else begin
         r_busy <= w_busyNext;
      end
   end

   assign busy_mask = r_busy;
`else
   logic w_unusedIssue;
   assign w_unusedIssue = ^{md_issue_valid, md_issue_addr};
   assign busy_mask     = {NREG{1'b0}};
`endif

   oneGrant : assert property (@(posedge clk) disable iff (rst) !(alu_ready && md_ready));

endmodule

// File: tb/tb_regs_wb_arbiter.sv
// Scoreboard bench for regs_wb_arbiter: stimulus pushes expected writes, a monitor pops on c_we.
// Scoreboard checks follow REGS_WB_SCOREBOARD_EN, matching the DUT build.
module tb_regs_wb_arbiter;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wr_t;

   logic                 clk;
   logic                 rst;
   logic                 alu_valid;
   logic [ADDR_W-1:0]    alu_addr;
   logic [DATA_W-1:0]    alu_data;
   logic                 alu_ready;
   logic                 md_valid;
   logic [ADDR_W-1:0]    md_addr;
   logic [DATA_W-1:0]    md_data;
   logic                 md_ready;
   logic                 md_issue_valid;
   logic [ADDR_W-1:0]    md_issue_addr;
   logic [ADDR_W-1:0]    c_addr;
   logic                 c_we;
   logic [DATA_W-1:0]    c_in;
   logic [2**ADDR_W-1:0] busy_mask;

   wr_t expQ[$];
   int  nChecks = 0;
   int  nFails  = 0;

   regs_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .STARVE_LIMIT(4)) dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
      .md_valid(md_valid), .md_addr(md_addr), .md_data(md_data), .md_ready(md_ready),
      .md_issue_valid(md_issue_valid), .md_issue_addr(md_issue_addr),
      .c_addr(c_addr), .c_we(c_we), .c_in(c_in), .busy_mask(busy_mask)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // One cycle: drive inputs just after the edge, check readies before the next edge,
   // and queue the register file write that the expected grant implies.
   task automatic applyStimulus(input string name,
                                input logic aV, input logic [ADDR_W-1:0] aA, input logic [DATA_W-1:0] aD,
                                input logic mV, input logic [ADDR_W-1:0] mA, input logic [DATA_W-1:0] mD,
                                input logic iV, input logic [ADDR_W-1:0] iA,
                                input logic expAluRdy, input logic expMdRdy);
      @(posedge clk);
      #1;
      alu_valid      = aV;
      alu_addr       = aA;
      alu_data       = aD;
      md_valid       = mV;
      md_addr        = mA;
      md_data        = mD;
      md_issue_valid = iV;
      md_issue_addr  = iA;
      #3;
      checkOutput({name, "_aluRdy"}, 64'(alu_ready), 64'(expAluRdy));
      checkOutput({name, "_mdRdy"}, 64'(md_ready), 64'(expMdRdy));
      if (expAluRdy && aA != '0) expQ.push_back('{addr: aA, data: aD});
      if (expMdRdy && mA != '0) expQ.push_back('{addr: mA, data: mD});
   endtask

   task automatic idleCycle(input string name);
      applyStimulus(name, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
   endtask

   // Monitor: every register file write must match the oldest expected write.
   always @(negedge clk) begin
      if (!rst && c_we) begin
         nChecks++;
         if (expQ.size() == 0) begin
            nFails++;
            $display("[TB] FAIL unexpectedWrite: got addr %0d data 0x%0h, expected no write", c_addr, c_in);
         end else begin
            wr_t e;
            e = expQ.pop_front();
            if (c_addr !== e.addr || c_in !== e.data) begin
               nFails++;
               $display("[TB] FAIL writePort: got addr %0d data 0x%0h, expected addr %0d data 0x%0h",
                        c_addr, c_in, e.addr, e.data);
            end
         end
      end
   end

   initial begin
      rst = 1'b1;
      alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
      md_valid = 1'b0;  md_addr = '0;  md_data = '0;
      md_issue_valid = 1'b0; md_issue_addr = '0;

      // Reset state, with a valid ALU request that must not be acknowledged
      repeat (2) @(posedge clk);
      #1;
      alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'h1111_1111;
      #3;
      checkOutput("rstAluRdy", 64'(alu_ready), 64'd0);
      checkOutput("rstWe", 64'(c_we), 64'd0);
      checkOutput("rstAddr", 64'(c_addr), 64'd0);
      checkOutput("rstIn", 64'(c_in), 64'd0);
      checkOutput("rstBusy", 64'(busy_mask), 64'd0);
      alu_valid = 1'b0;
      #2;
      rst = 1'b0;

      // Reset mid-transfer: the dropped handshake completes after release
      @(posedge clk);
      #1;
      alu_valid = 1'b1; alu_addr = 5'd9; alu_data = 32'h1234_5678;
      #3;
      checkOutput("midPreRdy", 64'(alu_ready), 64'd1);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("midRstRdy", 64'(alu_ready), 64'd0);
      checkOutput("midRstWe", 64'(c_we), 64'd0);
      checkOutput("midRstBusy", 64'(busy_mask), 64'd0);
      @(posedge clk);
      #2;
      rst = 1'b0;
      #2;
      checkOutput("midPostRdy", 64'(alu_ready), 64'd1);
      expQ.push_back('{addr: 5'd9, data: 32'h1234_5678});
      idleCycle("midIdle");
      checkOutput("midWe", 64'(c_we), 64'd1);

      // Single ALU write: visible for exactly one cycle
      applyStimulus("alu5", 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0);
      idleCycle("alu5n1");
      checkOutput("alu5We", 64'(c_we), 64'd1);
      checkOutput("alu5Addr", 64'(c_addr), 64'd5);
      checkOutput("alu5In", 64'(c_in), 64'hDEAD_BEEF);
      idleCycle("alu5n2");
      checkOutput("alu5WeOff", 64'(c_we), 64'd0);
      checkOutput("alu5Hold", 64'(c_in), 64'hDEAD_BEEF);

      // Contention: ALU x4, then MD on the fifth cycle, then ALU resumes
      applyStimulus("cont0", 1'b1, 5'd2, 32'hA000_0000, 1'b1, 5'd12, 32'hCAFE_0001, 1'b0, '0, 1'b1, 1'b0);
      applyStimulus("cont1", 1'b1, 5'd3, 32'hA000_0001, 1'b1, 5'd12, 32'hCAFE_0001, 1'b0, '0, 1'b1, 1'b0);
      applyStimulus("cont2", 1'b1, 5'd4, 32'hA000_0002, 1'b1, 5'd12, 32'hCAFE_0001, 1'b0, '0, 1'b1, 1'b0);
      applyStimulus("cont3", 1'b1, 5'd6, 32'hA000_0003, 1'b1, 5'd12, 32'hCAFE_0001, 1'b0, '0, 1'b1, 1'b0);
      applyStimulus("cont4", 1'b1, 5'd8, 32'hA000_0004, 1'b1, 5'd12, 32'hCAFE_0001, 1'b0, '0, 1'b0, 1'b1);
      applyStimulus("cont5", 1'b1, 5'd8, 32'hA000_0004, 1'b1, 5'd13, 32'hCAFE_0002, 1'b0, '0, 1'b1, 1'b0);
      applyStimulus("cont6", 1'b0, '0, '0, 1'b1, 5'd13, 32'hCAFE_0002, 1'b0, '0, 1'b0, 1'b1);
      idleCycle("contIdle");

      // Address 0: accepted but never written
      applyStimulus("addr0", 1'b0, '0, '0, 1'b1, 5'd0, 32'h0BAD_0000, 1'b0, '0, 1'b0, 1'b1);
      idleCycle("addr0n1");
      checkOutput("addr0We", 64'(c_we), 64'd0);

`ifdef REGS_WB_SCOREBOARD_EN
      applyStimulus("sbIssue", 1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd7, 1'b0, 1'b0);
      idleCycle("sbIdle1");
      checkOutput("sbSet", 64'(busy_mask), 64'h80);
      applyStimulus("sbWb", 1'b0, '0, '0, 1'b1, 5'd7, 32'h0000_0077, 1'b0, '0, 1'b0, 1'b1);
      idleCycle("sbIdle2");
      checkOutput("sbClr", 64'(busy_mask), 64'h0);
      applyStimulus("sbIssue2", 1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd7, 1'b0, 1'b0);
      applyStimulus("sbBoth", 1'b0, '0, '0, 1'b1, 5'd7, 32'h0000_0078, 1'b1, 5'd7, 1'b0, 1'b1);
      applyStimulus("sbIssue0", 1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd0, 1'b0, 1'b0);
      checkOutput("sbSetWins", 64'(busy_mask), 64'h80);
      idleCycle("sbIdle3");
      checkOutput("sbZeroIgnored", 64'(busy_mask), 64'h80);
`else
      applyStimulus("nsIssue", 1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd7, 1'b0, 1'b0);
      applyStimulus("nsIssue2", 1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd7, 1'b0, 1'b0);
      checkOutput("nsBusy1", 64'(busy_mask), 64'h0);
      idleCycle("nsIdle1");
      checkOutput("nsBusy2", 64'(busy_mask), 64'h0);
      idleCycle("nsIdle2");
      checkOutput("nsBusy3", 64'(busy_mask), 64'h0);
`endif

      idleCycle("drain1");
      idleCycle("drain2");
      checkOutput("pendingWrites", 64'(expQ.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule

// File: doc/regs_wb_arbiter.md
Name: regs_wb_arbiter

Overview:
- Shares the register file's single write port between two writeback sources: the ALU pipeline and the multi-cycle mul/div unit.
- Drives the register file's write port signals c_addr, c_we and c_in from registered outputs.
- Uses a valid/ready handshake on each source, ALU priority and a starvation guard for mul/div.
- Optionally keeps a busy-register scoreboard for decode-stage stalls.

Parameters:
- DATA_W, 32, width of writeback data.
- ADDR_W, 5, register address width (32 registers).
- STARVE_LIMIT, 4, number of consecutive blocked mul/div cycles before mul/div wins over the ALU. Legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- alu_valid  in  1  ALU result pending.
- alu_addr  in  ADDR_W  ALU destination register.
- alu_data  in  DATA_W  ALU result.
- alu_ready  out  1  ALU result accepted this cycle.
- md_valid  in  1  mul/div result pending.
- md_addr  in  ADDR_W  mul/div destination register.
- md_data  in  DATA_W  mul/div result.
- md_ready  out  1  mul/div result accepted this cycle.
- md_issue_valid  in  1  mul/div op issued this cycle (scoreboard set).
- md_issue_addr  in  ADDR_W  destination register of the issued op.
- c_addr  out  ADDR_W  register file write address (registered).
- c_we  out  1  register file write enable (registered).
- c_in  out  DATA_W  register file write data (registered).
- busy_mask  out  2**ADDR_W  one bit per register; set means a mul/div write is outstanding.

Behaviour:
- Reset (async, rst=1): c_we=0, c_addr=0, c_in=0, wait_cnt=0, busy_mask=0. alu_ready and md_ready are forced to 0 while rst=1. A handshake in progress when reset asserts is dropped; the source must re-present it.
- Handshake: a transfer occurs on a rising edge where valid=1 and ready=1. Ready is combinational from the valid inputs and wait_cnt. A source must hold valid, addr and data stable until it is accepted. At most one grant per cycle.
- Grant rule:
  - md_grant = md_valid & (~alu_valid | wait_cnt >= STARVE_LIMIT).
  - alu_grant = alu_valid & ~md_grant.
- wait_cnt (4 bit, saturating at 15):
  - Increments each cycle md_valid=1 and md_grant=0.
  - Clears to 0 on md_grant or when md_valid=0.
- Write port timing:
  - A transfer accepted in cycle N appears on c_addr/c_in with c_we=1 in cycle N+1, for exactly one cycle.
  - With no transfer, c_we=0 next cycle; c_addr and c_in hold their last value.
  - Latency is therefore 1 cycle. With the register file's same-cycle forwarding, a read of that address issued in N+1 returns the new data.
- Address 0: the transfer is accepted normally (ready asserts), but c_we stays 0 and nothing is written.
- Ordering: there is no ordering guarantee between the two sources for the same register. Issue logic must prevent cross-source WAW hazards, using busy_mask when the optional feature is enabled.
- Back-to-back: a continuous ALU stream with md_valid held gives ALU, ALU, ALU, ALU, then MD (for STARVE_LIMIT=4), then ALU resumes.

Optional Feature:
- Macro: REGS_WB_SCOREBOARD_EN.
- When defined:
  - md_issue_valid=1 with md_issue_addr≠0 sets busy_mask[md_issue_addr] at the clock edge.
  - An accepted md transfer clears busy_mask[md_addr].
  - If a set and a clear hit the same bit in the same cycle, the set wins.
  - Issuing to a register that is already busy leaves the bit set.
  - busy_mask[0] is always 0.
- When not defined: busy_mask is tied to 0 and the md_issue_* inputs are ignored. Ports are present in both builds.

Test Plan:
- Reset mid-transfer: assert rst while alu_valid=1 and alu_ready=1 -> c_we=0, alu_ready=0 during reset, busy_mask=0. After release the ALU transfer completes on the next cycle.
- Single ALU write: alu_valid=1, addr=5, data=0xDEADBEEF in cycle N -> alu_ready=1 in N; c_we=1, c_addr=5, c_in=0xDEADBEEF in N+1; c_we=0 in N+2.
- Contention with STARVE_LIMIT=4: both valid continuously with distinct ALU data each cycle -> grants ALU×4, then MD once, then ALU. md_ready is high exactly in cycle 5.
- Address 0: md_valid=1, md_addr=0, alu_valid=0 -> md_ready=1 and c_we stays 0 the following cycle.
- Scoreboard (REGS_WB_SCOREBOARD_EN): issue addr 7 -> busy_mask[7]=1 next cycle. md writeback to 7 accepted -> busy_mask[7]=0 next cycle. Same-cycle issue and writeback to 7 -> bit remains 1.
- No feature: md_issue_valid=1, addr 7 -> busy_mask stays 0 for all cycles.
